vedic_multiplier_pipe: RTL and testbench

Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier. Generalises the 4-bit combinational Vedic multiplier to WIDTH bits.
- Stage 1 forms all 2x2 Vedic sub-products. Each later stage merges four half-width products into one double-width product.
- Supports per-transaction signed/unsigned mode and valid/ready flow control.
- Sits between datapath producers and accumulators in the DSP blocks. Accepts one operation per cycle when not stalled.

---
 rtl/vedic_multiplier_pipe.sv | 146 ++++++++++++++
 tb/tb_vedic_multiplier_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_multiplier_pipe.sv
// rtl/vedic_multiplier_pipe.sv - pipelined Urdhva-Tiryagbhyam multiplier with signed/unsigned mode and valid/ready flow
module vedic_multiplier_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    // One register stage per doubling of operand width: 2x2 leaves, then log2(WIDTH)-1 merges.
    localparam int LAT = $clog2(WIDTH);

    if (WIDTH < 4 || WIDTH > 32 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("vedic_multiplier_pipe: WIDTH must be a power of two between 4 and 32");
    end

    // 2x2 Vedic cell: vertical, crosswise, vertical.
    function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
        logic cross_lo;
        logic cross_hi;
        logic top;
        logic carry;
        cross_lo = x[1] & y[0];
        cross_hi = x[0] & y[1];
        top      = x[1] & y[1];
        carry    = cross_lo & cross_hi;
        return {top & carry, top ^ carry, cross_lo ^ cross_hi, x[0] & y[0]};
    endfunction

    logic             adv;
    logic             take;
    logic             init_q;
    logic [LAT:1]     vld_q;
    logic [LAT:1]     vld_d;
    logic [LAT-1:1]   neg_q;
    logic [LAT-1:1]   neg_d;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_in;

    // Global stall: the whole pipe moves only when the output slot is free or being drained.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && init_q;
    assign take      = in_valid && in_ready;
    assign out_valid = vld_q[LAT];

    // Magnitudes and result sign; |-2^(WIDTH-1)| still fits as an unsigned WIDTH-bit value.
    always_comb begin
        mag_a  = a;
        mag_b  = b;
        neg_in = 1'b0;
        if (is_signed) begin
            if (a[WIDTH-1]) mag_a = -a;
            if (b[WIDTH-1]) mag_b = -b;
            neg_in = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

    // Next-state of the valid and sign shift chains.
    always_comb begin
        vld_d    = '0;
        neg_d    = '0;
        vld_d[1] = take;
        neg_d[1] = neg_in;
        for (int k = 2; k <= LAT; k++) vld_d[k] = vld_q[k-1];
        for (int k = 2; k < LAT; k++)  neg_d[k] = neg_q[k-1];
    end

    // Valid chain and the post-reset ready qualifier; cleared asynchronously so in-flight work is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (adv) vld_q <= vld_d;
        end
    end

    // Sign travels alongside the partial products; it is only meaningful when the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (adv) neg_q <= neg_d;
    end

    for (genvar l = 1; l <= LAT; l++) begin : g_lvl
        localparam int N  = 1 << l;      // operand width of the products held at this level
        localparam int M  = WIDTH / N;   // operand chunks per side
        localparam int PW = 2 * N;       // width of each product at this level

        logic [M*M*PW-1:0] prod_d;
        logic [M*M*PW-1:0] prod_q;

        if (l == 1) begin : g_leaf
            // All 2x2 sub-products; slot i*M+j holds a-chunk i times b-chunk j.
            always_comb begin
                prod_d = '0;
                for (int i = 0; i < M; i++) begin
                    for (int j = 0; j < M; j++) begin
                        prod_d[(i*M+j)*PW +: PW] = vedic2x2(mag_a[2*i +: 2], mag_b[2*j +: 2]);
                    end
                end
            end
        end else begin : g_merge
            localparam int MP = 2 * M;   // chunks per side at the previous level
            // Merge four half-width products: HH<<N + (LH+HL)<<(N/2) + LL, evaluated at full PW width.
            always_comb begin
                prod_d = '0;
                for (int i = 0; i < M; i++) begin
                    for (int j = 0; j < M; j++) begin
                        prod_d[(i*M+j)*PW +: PW] =
                            {g_lvl[l-1].prod_q[((2*i+1)*MP + 2*j+1)*N +: N],
                             g_lvl[l-1].prod_q[((2*i)*MP + 2*j)*N +: N]}
                          + ({{N{1'b0}}, g_lvl[l-1].prod_q[((2*i)*MP + 2*j+1)*N +: N]} << (N/2))
                          + ({{N{1'b0}}, g_lvl[l-1].prod_q[((2*i+1)*MP + 2*j)*N +: N]} << (N/2));
                    end
                end
            end
        end

        if (l == LAT) begin : g_out
            // Output register: applies the sign and is the only data register cleared by reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prod_q <= '0;
                end else if (adv) begin
                    prod_q <= neg_q[LAT-1] ? -prod_d : prod_d;
                end
            end
        end else begin : g_mid
            // Intermediate partial-product register, loaded in lockstep with the valid chain.
            always_ff @(posedge clk) begin
                if (adv) prod_q <= prod_d;
            end
        end
    end

    assign product = g_lvl[LAT].prod_q;

endmodule

// File: tb/tb_vedic_multiplier_pipe.sv
// tb/tb_vedic_multiplier_pipe.sv - directed and table-driven bench for vedic_multiplier_pipe
module tb_vedic_multiplier_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic ordy_s;

    logic        iv8, rdy8, s8, ov8, ordy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        iv4, rdy4, s4, ov4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        iv16, rdy16, s16, ov16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic        iv32, rdy32, s32, ov32;
    logic [31:0] a32, b32;
    logic [63:0] p32;

    vedic_multiplier_pipe #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .a(a8), .b(b8),
        .is_signed(s8), .out_valid(ov8), .out_ready(ordy8), .product(p8));
    vedic_multiplier_pipe #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4), .a(a4), .b(b4),
        .is_signed(s4), .out_valid(ov4), .out_ready(ordy_s), .product(p4));
    vedic_multiplier_pipe #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16), .a(a16), .b(b16),
        .is_signed(s16), .out_valid(ov16), .out_ready(ordy_s), .product(p16));
    vedic_multiplier_pipe #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32), .a(a32), .b(b32),
        .is_signed(s32), .out_valid(ov32), .out_ready(ordy_s), .product(p32));

    int n_chk  = 0;
    int n_fail = 0;
    int n_sent8 = 0;
    int n_out8  = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[15];

    logic [15:0] q8[$];
    logic [7:0]  q4[$];
    logic [31:0] q16[$];
    logic [63:0] q32[$];

    logic        bp_win = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_p = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic s, input int w);
        logic [63:0] xe, ye, p;
        for (int i = 0; i < 64; i++) begin
            xe[i] = (i < w) ? x[i & 31] : (s & x[w-1]);
            ye[i] = (i < w) ? y[i & 31] : (s & y[w-1]);
        end
        p = xe * ye;
        if (w < 32) p = p & ((64'd1 << (2*w)) - 64'd1);
        return p;
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic [63:0] r;
        r = ref_mul({24'd0, x}, {24'd0, y}, s, 8);
        return r[15:0];
    endfunction

    // WIDTH=8 output monitor: ordering, hold-under-stall, and ready rule during the backpressure window.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("w8_hold_valid", ov8, 1);
                check("w8_hold_product", p8, prev_p);
            end
            if (bp_win) check("w8_in_ready_rule", rdy8, !ov8 || ordy8);
            prev_stall = ov8 && !ordy8;
            prev_p = p8;
            if (ov8 && ordy8) begin
                n_out8++;
                if (q8.size() == 0) check("w8_extra_output", ov8, 0);
                else check("w8_product", p8, q8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov4) begin
            if (q4.size() == 0) check("w4_extra_output", ov4, 0);
            else check("w4_product", p4, q4.pop_front());
        end
        if (rst_n && ov16) begin
            if (q16.size() == 0) check("w16_extra_output", ov16, 0);
            else check("w16_product", p16, q16.pop_front());
        end
        if (rst_n && ov32) begin
            if (q32.size() == 0) check("w32_extra_output", ov32, 0);
            else check("w32_product", p32, q32.pop_front());
        end
    end

    task automatic send8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                         input logic [15:0] te);
        int w = 0;
        a8 = ta; b8 = tb; s8 = ts; iv8 = 1'b1;
        @(negedge clk);
        while (!rdy8 && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (w >= 100) check("send8_timeout", rdy8, 1);
        else begin
            q8.push_back(te);
            n_sent8++;
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic drain8();
        int w = 0;
        while (q8.size() != 0 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        check("w8_drain", q8.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ta, tb;
        logic        ts;
        logic [15:0] e3[3];
        logic [63:0] r;
        bit          done;
        int          base;

        vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[1]  = '{8'h0D, 8'h0B, 1'b0, 16'h008F};
        vecs[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[3]  = '{8'hFF, 8'h7F, 1'b1, 16'hFF81};
        vecs[4]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[5]  = '{8'h00, 8'h80, 1'b1, 16'h0000};
        vecs[6]  = '{8'h80, 8'h00, 1'b1, 16'h0000};
        vecs[7]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[8]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        vecs[9]  = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
        vecs[10] = '{8'h80, 8'hFF, 1'b1, 16'h0080};
        vecs[11] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
        vecs[12] = '{8'hAB, 8'hCD, 1'b0, 16'h88EF};
        vecs[13] = '{8'hAB, 8'hCD, 1'b1, 16'h10EF};
        vecs[14] = '{8'h05, 8'hFD, 1'b1, 16'hFFF1};

        rst_n = 1'b1; ordy_s = 1'b1; ordy8 = 1'b1;
        iv8 = 0; a8 = 0; b8 = 0; s8 = 0;
        iv4 = 0; a4 = 0; b4 = 0; s4 = 0;
        iv16 = 0; a16 = 0; b16 = 0; s16 = 0;
        iv32 = 0; a32 = 0; b32 = 0; s32 = 0;
        done = 0;

        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        check("reset_out_valid", ov8, 0);
        check("reset_product", p8, 0);
        check("reset_w32_product", p32, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", rdy8, 1);
        check("idle_out_valid", ov8, 0);

        // First transaction latency: driven after edge 0, valid after edge 3.
        a8 = 8'hFF; b8 = 8'hFF; s8 = 0; iv8 = 1;
        q8.push_back(16'hFE01); n_sent8++;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 1) iv8 = 0;
            check("lat_w8_valid", ov8, k == 3);
        end
        check("lat_w8_product", p8, 16'hFE01);
        send8(8'h0D, 8'h0B, 1'b0, 16'h008F);
        drain8();

        // Table vectors, back to back.
        for (int i = 0; i < 15; i++) send8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);
        drain8();
        repeat (2) @(posedge clk); #1;

        // Signed results on three consecutive cycles.
        e3[0] = 16'h4000; e3[1] = 16'hFF81; e3[2] = 16'hC080;
        for (int i = 0; i < 3; i++) begin
            a8 = vecs[2+i].a; b8 = vecs[2+i].b; s8 = 1'b1; iv8 = 1;
            q8.push_back(e3[i]); n_sent8++;
            @(posedge clk); #1;
        end
        iv8 = 0;
        for (int k = 0; k < 3; k++) begin
            check("b2b_valid", ov8, 1);
            check("b2b_product", p8, e3[k]);
            @(posedge clk); #1;
        end
        check("b2b_idle", ov8, 0);

        // Backpressure: five ops, out_ready low for four cycles.
        base = n_out8;
        bp_win = 1;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    ta = 8'($urandom); tb = 8'($urandom); ts = 1'($urandom);
                    send8(ta, tb, ts, ref8(ta, tb, ts));
                end
            end
            begin
                repeat (4) @(posedge clk); #1 ordy8 = 0;
                repeat (2) @(posedge clk); #1;
                check("bp_in_ready_low", rdy8, 0);
                repeat (2) @(posedge clk); #1 ordy8 = 1;
            end
        join
        drain8();
        bp_win = 0;
        check("bp_count", n_out8 - base, 5);

        // Bubbles: in_valid 1,0,1,0 with junk data on the idle cycles.
        repeat (2) @(posedge clk); #1;
        a8 = 8'h21; b8 = 8'h03; s8 = 0; iv8 = 1;
        q8.push_back(16'h0063); n_sent8++;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (n >= 3) check("bubble_valid", ov8, ((n - 3) % 2) == 0);
            if (n <= 3) begin
                a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
                iv8 = (n % 2) == 0;
                if (iv8) begin
                    q8.push_back(ref8(a8, b8, s8)); n_sent8++;
                end
            end else iv8 = 0;
        end
        drain8();

        // Reset mid-flight: op0 at the output, two more in flight.
        repeat (2) @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'hFF; s8 = 0; iv8 = 1;
        @(posedge clk); #1 a8 = 8'h12; b8 = 8'h34;
        @(posedge clk); #1 a8 = 8'h05; b8 = 8'h07;
        @(posedge clk); #1 iv8 = 0;
        check("pre_reset_valid", ov8, 1);
        check("pre_reset_product", p8, 16'hFE01);
        #1 rst_n = 0;
        #1;
        check("midreset_out_valid", ov8, 0);
        check("midreset_product", p8, 0);
        #1 rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("no_ghost_after_reset", ov8, 0);
        end
        send8(8'h0D, 8'h0B, 1'b0, 16'h008F);
        drain8();

        // Random stream with random out_ready.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    ta = 8'($urandom); tb = 8'($urandom); ts = 1'($urandom);
                    send8(ta, tb, ts, ref8(ta, tb, ts));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    ordy8 = $urandom_range(0, 3) != 0;
                end
                ordy8 = 1;
            end
        join
        drain8();
        check("w8_count", n_out8, n_sent8);

        // Other widths: directed latency corners.
        @(posedge clk); #1;
        a4 = 4'hF; b4 = 4'hF; s4 = 0; iv4 = 1; q4.push_back(8'hE1);
        a16 = 16'h8000; b16 = 16'h8000; s16 = 1; iv16 = 1; q16.push_back(32'h4000_0000);
        a32 = 32'h8000_0000; b32 = 32'h8000_0000; s32 = 1; iv32 = 1;
        q32.push_back(64'h4000_0000_0000_0000);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                iv4 = 0; iv16 = 0; iv32 = 0;
            end
            check("lat_w4_valid", ov4, k == 2);
            check("lat_w16_valid", ov16, k == 4);
            check("lat_w32_valid", ov32, k == 5);
            if (k == 2) check("lat_w4_product", p4, 8'hE1);
            if (k == 5) check("lat_w32_product", p32, 64'h4000_0000_0000_0000);
        end

        // Other widths: random signed/unsigned stream against the reference model.
        for (int i = 0; i < 100; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom); iv4 = 1;
            r = ref_mul({28'd0, a4}, {28'd0, b4}, s4, 4); q4.push_back(r[7:0]);
            a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom); iv16 = 1;
            r = ref_mul({16'd0, a16}, {16'd0, b16}, s16, 16); q16.push_back(r[31:0]);
            a32 = $urandom; b32 = $urandom; s32 = 1'($urandom); iv32 = 1;
            q32.push_back(ref_mul(a32, b32, s32, 32));
            @(posedge clk); #1;
        end
        iv4 = 0; iv16 = 0; iv32 = 0;
        repeat (10) @(posedge clk); #1;
        check("w4_drain", q4.size(), 0);
        check("w16_drain", q16.size(), 0);
        check("w32_drain", q32.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
